// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state codes and state type for the instruction/data RAM arbiter.
// Optional feature: ARB_TIMEOUT_EN enables the grant-wait watchdog.
package mem_bus_arbiter_pkg;

   localparam logic [1:0] ArbIdle   = 2'd0;
   localparam logic [1:0] ArbIGrant = 2'd1;
   localparam logic [1:0] ArbDGrant = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = ArbIdle,
      ST_IGRANT = ArbIGrant,
      ST_DGRANT = ArbDGrant
   } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_wdog.sv
// Grant-wait watchdog: counts cycles spent waiting on ram_ready_i and flags expiry.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_timeout_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle that is not a plain wait (completion, abort, idle) restarts the count.
   always_comb begin
      cnt_d = '0;
      if (wait_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = wait_i && (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port RAM between the fetch port and the MEM-stage data port (data has priority).
// Optional feature: define ARB_TIMEOUT_EN to abort grants whose RAM never becomes ready.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ice_i,
   input  logic [ADDR_W-1:0]   iaddr_i,
   output logic                iack_o,
   output logic [DATA_W-1:0]   irdata_o,
   input  logic                dce_i,
   input  logic                dwe_i,
   input  logic [DATA_W/8-1:0] dsel_i,
   input  logic [ADDR_W-1:0]   daddr_i,
   input  logic [DATA_W-1:0]   dwdata_i,
   output logic                dack_o,
   output logic [DATA_W-1:0]   drdata_o,
   output logic                stall_o,
   output logic                ram_ce_o,
   output logic                ram_we_o,
   output logic [DATA_W/8-1:0] ram_sel_o,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [DATA_W-1:0]   ram_wdata_o,
   input  logic [DATA_W-1:0]   ram_rdata_i,
   input  logic                ram_ready_i,
   output logic                bus_err_o
);

   localparam int SEL_W = DATA_W / 8;

   arb_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic granted;
   logic done;
   logic expired;
   logic arbitrate;

   assign granted = (state_q != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
   logic waiting;

   assign waiting = granted && !ram_ready_i;

   arb_timeout_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .wait_i    (waiting),
      .expired_o (expired)
   );

   assign bus_err_o = !rst && expired;
`else
   assign expired   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   assign done      = granted && (ram_ready_i || expired);
   assign arbitrate = (state_q == ST_IDLE) || (done && !expired);

   // Re-arbitration excludes the port that just completed so a held request is not served twice;
   // an aborted grant always falls back to IDLE.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (!granted || done) begin
         state_d = ST_IDLE;
         we_d    = 1'b0;
         sel_d   = '0;
         addr_d  = '0;
         wdata_d = '0;
         if (arbitrate && dce_i && (state_q != ST_DGRANT)) begin
            state_d = ST_DGRANT;
            we_d    = dwe_i;
            sel_d   = dsel_i;
            addr_d  = daddr_i;
            wdata_d = dwdata_i;
         end else if (arbitrate && ice_i && (state_q != ST_IGRANT)) begin
            state_d = ST_IGRANT;
            sel_d   = '1;
            addr_d  = iaddr_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign iack_o   = !rst && (state_q == ST_IGRANT) && done;
   assign dack_o   = !rst && (state_q == ST_DGRANT) && done;
   assign irdata_o = expired ? '0 : ram_rdata_i;
   assign drdata_o = expired ? '0 : ram_rdata_i;
   assign stall_o  = !rst && ((ice_i && !iack_o) || (dce_i && !dack_o));

   assign ram_ce_o    = granted;
   assign ram_we_o    = we_q;
   assign ram_sel_o   = sel_q;
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;

endmodule
